// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback/commit stage: lane bundle layout,
// CSR address type and a small popcount helper for retire counting.
package wb_commit_pkg;

    localparam int CSR_ADDR_WIDTH = 14;
    localparam int REG_ADDR_W     = 5;
    localparam int REG_W          = 32;
    localparam int PC_WIDTH       = 32;
    localparam int CSR_DATA_WIDTH = 32;
    localparam int MAX_LANES      = 4;

    typedef logic [CSR_ADDR_WIDTH-1:0] csr_addr_t;

    // One commit lane as delivered by the memory stage.
    typedef struct packed {
        logic                      valid;
        logic [PC_WIDTH-1:0]       pc;
        logic                      reg_we;
        logic [REG_ADDR_W-1:0]     reg_addr;
        logic [REG_W-1:0]          reg_data;
        logic                      csr_we;
        csr_addr_t                 csr_addr;
        logic [CSR_DATA_WIDTH-1:0] csr_data;
        logic                      is_llw;
        logic                      is_scw;
    } wb_lane_t;

    // Number of set bits in a lane-valid vector (up to MAX_LANES lanes).
    function automatic logic [2:0] popcount4(input logic [MAX_LANES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/wb_waw_resolve.sv
// Combinational lane-priority logic for the commit stage:
//  - register writes: youngest lane wins on an address collision, r0 never written
//  - CSR writes: oldest lane with csr_we wins, flag when more than one competes
module wb_waw_resolve
    import wb_commit_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2
) (
    input  logic [ISSUE_WIDTH-1:0]                 i_valid,
    input  logic [ISSUE_WIDTH-1:0]                 i_reg_we,
    input  logic [ISSUE_WIDTH-1:0][REG_ADDR_W-1:0] i_reg_addr,
    input  logic [ISSUE_WIDTH-1:0]                 i_csr_we,
    output logic [ISSUE_WIDTH-1:0]                 o_reg_mask,
    output logic [ISSUE_WIDTH-1:0]                 o_csr_sel,
    output logic                                   o_csr_conflict
);

    logic [ISSUE_WIDTH-1:0] w_reg_cand;
    logic [ISSUE_WIDTH-1:0] w_csr_cand;

    // Lanes that would write at all: live, enabled, and not targeting r0.
    always_comb begin
        w_reg_cand = '0;
        w_csr_cand = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            w_reg_cand[i] = i_valid[i] && i_reg_we[i] && (i_reg_addr[i] != '0);
            w_csr_cand[i] = i_valid[i] && i_csr_we[i];
        end
    end

    // Drop an older lane's write when any younger lane writes the same register.
    always_comb begin
        o_reg_mask = w_reg_cand;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            for (int j = i + 1; j < ISSUE_WIDTH; j++) begin
                if (w_reg_cand[i] && w_reg_cand[j] && (i_reg_addr[i] == i_reg_addr[j])) begin
                    o_reg_mask[i] = 1'b0;
                end
            end
        end
    end

    // Lowest set bit isolates the oldest CSR writer; clearing it leaves
    // something behind only if a second writer exists.
    always_comb begin
        o_csr_sel      = w_csr_cand & (~w_csr_cand + ISSUE_WIDTH'(1));
        o_csr_conflict = |(w_csr_cand & (w_csr_cand - ISSUE_WIDTH'(1)));
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: latches an ISSUE_WIDTH-wide bundle from mem,
// resolves intra-bundle WAW and CSR contention, drives regfile/CSR writes,
// and owns LLbit plus the retired-instruction counter. Side effects fire
// only in the cycle the bundle actually leaves (stage not stalled).
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int ISSUE_WIDTH    = 2,
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int REG_WIDTH      = REG_W,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  wb_lane_t [ISSUE_WIDTH-1:0]               wb_i,
    input  logic                                     flush,
    input  logic                                     stall,
    input  logic                                     stall_next,
    output logic [ISSUE_WIDTH-1:0]                   reg_write_en,
    output logic [ISSUE_WIDTH-1:0][REG_ADDR_WIDTH-1:0] reg_write_addr,
    output logic [ISSUE_WIDTH-1:0][REG_WIDTH-1:0]    reg_write_data,
    output logic                                     csr_write_en,
    output csr_addr_t                                csr_write_addr,
    output logic [CSR_DATA_WIDTH-1:0]                csr_write_data,
    output logic                                     csr_conflict,
    output logic                                     llbit,
    output logic [ISSUE_WIDTH-1:0]                   commit_valid,
    output logic [ISSUE_WIDTH-1:0][PC_WIDTH-1:0]     commit_pc,
    output logic [CNT_WIDTH-1:0]                     retire_count
);

    wb_lane_t [ISSUE_WIDTH-1:0]                 r_stage;
    logic                                       r_llbit;
    logic [CNT_WIDTH-1:0]                       r_retire;

    logic                                       w_fire;
    logic [ISSUE_WIDTH-1:0]                     w_live;
    logic [ISSUE_WIDTH-1:0]                     w_reg_we;
    logic [ISSUE_WIDTH-1:0][REG_ADDR_W-1:0]     w_reg_addr;
    logic [ISSUE_WIDTH-1:0]                     w_csr_we;
    logic [ISSUE_WIDTH-1:0]                     w_reg_mask;
    logic [ISSUE_WIDTH-1:0]                     w_csr_sel;
    logic                                       w_csr_conflict;
    logic [MAX_LANES-1:0]                       w_valid4;
    logic                                       w_ll_next;

    // The held bundle leaves (and may cause side effects) only when not paused.
    assign w_fire = !stall;

    // Stage register: flush or a pause that lets downstream run inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else if (flush || (stall && !stall_next)) begin
            r_stage <= '0;
        end else if (!stall) begin
            r_stage <= wb_i;
        end
    end

    // Unpack the lane fields the resolver needs, qualified by the fire cycle.
    always_comb begin
        w_live     = '0;
        w_reg_we   = '0;
        w_reg_addr = '0;
        w_csr_we   = '0;
        w_valid4   = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            w_live[i]     = r_stage[i].valid && w_fire;
            w_reg_we[i]   = r_stage[i].reg_we;
            w_reg_addr[i] = r_stage[i].reg_addr;
            w_csr_we[i]   = r_stage[i].csr_we;
            w_valid4[i]   = r_stage[i].valid;
        end
    end

    wb_waw_resolve #(
        .ISSUE_WIDTH (ISSUE_WIDTH)
    ) u_resolve (
        .i_valid        (w_live),
        .i_reg_we       (w_reg_we),
        .i_reg_addr     (w_reg_addr),
        .i_csr_we       (w_csr_we),
        .o_reg_mask     (w_reg_mask),
        .o_csr_sel      (w_csr_sel),
        .o_csr_conflict (w_csr_conflict)
    );

    // Per-lane regfile and commit outputs straight from the stage register.
    always_comb begin
        reg_write_en   = w_reg_mask;
        reg_write_addr = '0;
        reg_write_data = '0;
        commit_valid   = w_live;
        commit_pc      = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (r_stage[i].valid) begin
                reg_write_addr[i] = REG_ADDR_WIDTH'(r_stage[i].reg_addr);
                reg_write_data[i] = REG_WIDTH'(r_stage[i].reg_data);
            end
            if (w_live[i]) begin
                commit_pc[i] = r_stage[i].pc;
            end
        end
    end

    // CSR port is a one-hot mux over the lanes; zero when nobody writes.
    always_comb begin
        csr_write_en   = |w_csr_sel;
        csr_write_addr = '0;
        csr_write_data = '0;
        csr_conflict   = w_csr_conflict;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (w_csr_sel[i]) begin
                csr_write_addr = r_stage[i].csr_addr;
                csr_write_data = r_stage[i].csr_data;
            end
        end
    end

    // Next LLbit from the bundle: later (younger) lanes override earlier ones.
    always_comb begin
        w_ll_next = r_llbit;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (r_stage[i].valid) begin
                if (r_stage[i].is_llw) begin
                    w_ll_next = 1'b1;
                end else if (r_stage[i].is_scw) begin
                    w_ll_next = 1'b0;
                end
            end
        end
    end

    // LLbit: flush always clears it, otherwise the departing bundle updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_llbit <= 1'b0;
        end else if (flush) begin
            r_llbit <= 1'b0;
        end else if (w_fire) begin
            r_llbit <= w_ll_next;
        end
    end

    // Retire counter: add the departing bundle's valid lanes, wrapping freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire <= '0;
        end else if (w_fire) begin
            r_retire <= r_retire + CNT_WIDTH'(popcount4(w_valid4));
        end
    end

    assign llbit        = r_llbit;
    assign retire_count = r_retire;

endmodule
